reflet_uart_bridge: RTL and testbench
=====================================

REFLET_UART_BRIDGE -- requirements
Module: reflet_uart_bridge

Interface
REQ-001 Parameters: wordsize, default 16, bus data width (multiple of 8); addr_size, default 16, bus address width (multiple of 8); clk_freq, default 1000000, clock frequency in Hz; baud, default 9600, serial bit rate.
REQ-002 Ports: clk, input, 1, sole clock, all state on rising edge.
REQ-003 Ports: reset, input, 1, asynchronous active-low reset.
REQ-004 Ports: rx, input, 1, serial in from host, idle high, asynchronous to clk.
REQ-005 Ports: tx, output, 1, serial out to host, idle high.
REQ-006 Ports: bus_addr, output, addr_size, system bus address.
REQ-007 Ports: bus_write_en, output, 1, one-cycle write strobe.
REQ-008 Ports: bus_data_out, output, wordsize, write data to bus.
REQ-009 Ports: bus_data_in, input, wordsize, combinational read data from bus.
REQ-010 Ports: busy, output, 1, high while a command is in progress (CPU hold request).

Function
REQ-011 Role: bus initiator driven from a host over 8N1 UART, LSB first; inverse end of the UART peripheral.
REQ-012 Bit period: divider = clk_freq/baud clocks, integer truncation.
REQ-013 rx passes through a 2-flop synchroniser before use.
REQ-014 RX: synchronised falling edge while idle starts a frame; start bit re-checked at half period (high -> abort, no byte); 8 data bits sampled at bit centres; stop bit sampled at centre.
REQ-015 Stop bit 0 = framing error: byte discarded, command FSM forced to IDLE.
REQ-016 Commands: 0x57 'W' = write, 0x52 'R' = read; any other byte in IDLE ignored.
REQ-017 Write: 'W', then addr_size/8 address bytes LSB first, then wordsize/8 data bytes LSB first.
REQ-018 Read: 'R', then addr_size/8 address bytes LSB first.
REQ-019 FSM states: IDLE, ADDR, DATA, BUS_WR, BUS_RD, SEND, ACK.
REQ-020 IDLE->ADDR on valid command; ADDR->DATA ('W') or BUS_RD ('R') after last address byte; DATA->BUS_WR after last data byte.
REQ-021 BUS_WR lasts exactly one cycle: bus_write_en=1 with bus_addr/bus_data_out stable; then ACK.
REQ-022 BUS_RD lasts exactly one cycle: bus_addr stable, bus_data_in captured at end of cycle; then SEND.
REQ-023 SEND transmits wordsize/8 bytes of captured data LSB first, back to back, one stop bit each; then IDLE.
REQ-024 ACK transmits one byte 0x4B 'K'; then IDLE.
REQ-025 Bytes completing reception during SEND or ACK are discarded.
REQ-026 busy=1 in every state except IDLE.
REQ-027 bus_write_en=0 outside BUS_WR; bus_addr and bus_data_out hold their last value between commands.
REQ-028 TX: start bit, 8 data bits, stop bit, each one divider period long.

Reset
REQ-029 Reset low asynchronously sets FSM IDLE, tx=1, busy=0, bus_write_en=0, bus_addr=0, bus_data_out=0, and clears divider, shift registers and synchroniser (to 1).
REQ-030 Reset mid-frame or mid-command abandons it with no bus access; the first frame after release starts from IDLE.

Structure
REQ-031 Command codes 0x57, 0x52, 0x4B and FSM state encodings live in a shared constants package/include.
REQ-032 Sub-module reflet_uart_bridge_phy holds the divider, synchroniser, RX/TX shifters, framing check and byte-valid/tx-ready handshakes; the top holds the FSM and bus registers.

Verification (clk_freq=96000, baud=9600, divider 10)
REQ-033 Write: send 57 34 12 CD AB -> one-cycle bus_write_en, bus_addr=0x1234, bus_data_out=0xABCD; tx sends 0x4B.
REQ-034 Read: bus_data_in=0xBEEF at 0x0010; send 52 10 00 -> one-cycle bus_addr=0x0010 access, no write strobe; tx sends EF then BE.
REQ-035 Junk: send 0x00, 0xFF, then 52 10 00 -> junk ignored, read completes normally.
REQ-036 Framing error: 57 with stop bit 0, then 52 10 00 -> no write, read completes.
REQ-037 Reset asserted mid-DATA: no bus_write_en, tx=1 and busy=0 immediately; following 'W' command completes.
REQ-038 Glitch: rx low for 3 clocks -> no byte received, FSM stays IDLE.

Source files
------------

// File: rtl/reflet_uart_bridge_pkg.sv
// Shared constants for the UART-to-bus bridge.
//   - host command codes and the acknowledge byte
//   - command FSM state encodings
//   - receiver state type used by the serial PHY
//   - bit-period divider helper
package reflet_uart_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] ACK_BYTE  = 8'h4B;  // 'K'

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_BUS_WR = 3'd3;
  localparam logic [2:0] ST_BUS_RD = 3'd4;
  localparam logic [2:0] ST_SEND   = 3'd5;
  localparam logic [2:0] ST_ACK    = 3'd6;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Clocks per serial bit; integer truncation is intended.
  function automatic int bit_divider(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/reflet_uart_bridge_if.sv
// System-bus side of the UART bridge.
//   bus_addr     : address driven by the bridge
//   bus_write_en : one-cycle write strobe
//   bus_data_out : write data
//   bus_data_in  : combinational read data returned by the bus
// master = the bridge, slave = the memory/peripheral side.
interface reflet_uart_bridge_if #(
  parameter int wordsize  = 16,
  parameter int addr_size = 16
);
  logic [addr_size-1:0] bus_addr;
  logic                 bus_write_en;
  logic [wordsize-1:0]  bus_data_out;
  logic [wordsize-1:0]  bus_data_in;

  modport master (
    output bus_addr,
    output bus_write_en,
    output bus_data_out,
    input  bus_data_in
  );

  modport slave (
    input  bus_addr,
    input  bus_write_en,
    input  bus_data_out,
    output bus_data_in
  );
endinterface

// File: rtl/reflet_uart_bridge_phy.sv
// 8N1 serial PHY for the UART bridge.
// Ports:
//   clk, reset    : clock, asynchronous active-low reset
//   rx            : serial input (asynchronous, idle high)
//   tx            : serial output (idle high)
//   rx_byte       : last received byte, valid with rx_valid
//   rx_valid      : one-cycle pulse, byte received with a good stop bit
//   rx_frame_err  : one-cycle pulse, stop bit sampled low (byte dropped)
//   tx_data       : byte to send, taken when tx_start is high
//   tx_start      : request to send tx_data; honoured only when tx_ready
//   tx_ready      : transmitter idle
module reflet_uart_bridge_phy
  import reflet_uart_bridge_pkg::*;
#(
  parameter int divider = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_frame_err,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready
);

  localparam int CW = $clog2(divider + 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(divider - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(divider / 2 - 1);

  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  rx_state_e     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;

  // Start bit is re-checked at its centre so that short low glitches are
  // dropped; every later sample lands one full period after the previous.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= HALF_LOAD;
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            if (rx_sync) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              rx_cnt   <= FULL_LOAD;
              rx_bit   <= 3'd0;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_cnt   <= FULL_LOAD;
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == '0) begin
            rx_state <= RX_IDLE;
            if (rx_sync) rx_valid     <= 1'b1;
            else         rx_frame_err <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign rx_byte = rx_shift;

  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bits;   // bit periods left in the current frame
  logic [7:0]    tx_shift;

  // The start bit is driven on the accept cycle; each expiry of the period
  // counter moves to the next bit. Ones are shifted in behind the data so
  // the stop bit falls out of the shifter after the eighth data bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx       <= 1'b1;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_shift <= '0;
    end else if (tx_bits == 4'd0) begin
      if (tx_start) begin
        tx       <= 1'b0;
        tx_shift <= tx_data;
        tx_bits  <= 4'd10;
        tx_cnt   <= FULL_LOAD;
      end
    end else if (tx_cnt == '0) begin
      tx       <= tx_shift[0];
      tx_shift <= {1'b1, tx_shift[7:1]};
      tx_bits  <= tx_bits - 4'd1;
      tx_cnt   <= FULL_LOAD;
    end else begin
      tx_cnt <= tx_cnt - 1'b1;
    end
  end

  assign tx_ready = (tx_bits == 4'd0);

endmodule

// File: rtl/reflet_uart_bridge.sv
// UART-driven bus initiator: a host issues write ('W') and read ('R')
// commands over 8N1 serial; the bridge performs the bus access and answers
// with 'K' (write) or the read word, LSB first.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   rx, tx     : serial link to the host
//   busy       : high while a command is in progress (CPU hold request)
//   bus        : bus master port (address, write strobe, write/read data)
//
// state     | meaning
// ----------+----------------------------------------------------
// ST_IDLE   | waiting for a command byte, other bytes ignored
// ST_ADDR   | collecting address bytes, LSB first
// ST_DATA   | collecting write data bytes, LSB first
// ST_BUS_WR | single-cycle write strobe
// ST_BUS_RD | single-cycle read, bus_data_in captured
// ST_SEND   | transmitting the captured word, LSB first
// ST_ACK    | transmitting the 'K' acknowledge
module reflet_uart_bridge
  import reflet_uart_bridge_pkg::*;
#(
  parameter int wordsize  = 16,
  parameter int addr_size = 16,
  parameter int clk_freq  = 1000000,
  parameter int baud      = 9600
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic tx,
  output logic busy,
  reflet_uart_bridge_if.master bus
);

  localparam int ADDR_BYTES = addr_size / 8;
  localparam int DATA_BYTES = wordsize / 8;
  localparam int DIVIDER    = bit_divider(clk_freq, baud);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_frame_err;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready;

  reflet_uart_bridge_phy #(
    .divider(DIVIDER)
  ) u_phy (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .tx          (tx),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_ready    (tx_ready)
  );

  logic [2:0]           state;
  logic                 is_write;
  logic [7:0]           byte_cnt;
  logic [addr_size-1:0] addr_acc;
  logic [addr_size-1:0] addr_next;
  logic [addr_size-1:0] addr_q;
  logic [wordsize-1:0]  data_acc;
  logic [wordsize-1:0]  data_next;
  logic [wordsize-1:0]  data_q;
  logic [wordsize-1:0]  rd_shift;

  // Bytes arrive LSB first: each new byte enters at the top and the
  // accumulator shifts down, so after the last byte it is aligned.
  assign addr_next = (addr_acc >> 8) | (addr_size'(rx_byte) << (addr_size - 8));
  assign data_next = (data_acc >> 8) | (wordsize'(rx_byte) << (wordsize - 8));

  // Assembly happens in addr_acc/data_acc; the bus registers are loaded only
  // on entry to a bus cycle so they hold steady between commands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      is_write <= 1'b0;
      byte_cnt <= '0;
      addr_acc <= '0;
      data_acc <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      rd_shift <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_valid && (rx_byte == CMD_WRITE || rx_byte == CMD_READ)) begin
            state    <= ST_ADDR;
            is_write <= (rx_byte == CMD_WRITE);
            byte_cnt <= '0;
          end
        end
        ST_ADDR: begin
          if (rx_frame_err) begin
            state <= ST_IDLE;
          end else if (rx_valid) begin
            addr_acc <= addr_next;
            byte_cnt <= byte_cnt + 8'd1;
            if (byte_cnt == 8'(ADDR_BYTES - 1)) begin
              byte_cnt <= '0;
              if (is_write) begin
                state <= ST_DATA;
              end else begin
                state  <= ST_BUS_RD;
                addr_q <= addr_next;
              end
            end
          end
        end
        ST_DATA: begin
          if (rx_frame_err) begin
            state <= ST_IDLE;
          end else if (rx_valid) begin
            data_acc <= data_next;
            byte_cnt <= byte_cnt + 8'd1;
            if (byte_cnt == 8'(DATA_BYTES - 1)) begin
              byte_cnt <= '0;
              state    <= ST_BUS_WR;
              addr_q   <= addr_acc;
              data_q   <= data_next;
            end
          end
        end
        ST_BUS_WR: begin
          state    <= ST_ACK;
          byte_cnt <= '0;
        end
        ST_BUS_RD: begin
          rd_shift <= bus.bus_data_in;
          state    <= ST_SEND;
          byte_cnt <= '0;
        end
        // byte_cnt counts bytes handed to the PHY; the state is left only
        // once the PHY is idle again, so busy covers the final stop bit.
        ST_SEND: begin
          if (tx_ready) begin
            if (byte_cnt == 8'(DATA_BYTES)) begin
              state <= ST_IDLE;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
              rd_shift <= rd_shift >> 8;
            end
          end
        end
        ST_ACK: begin
          if (tx_ready) begin
            if (byte_cnt == 8'd1) state <= ST_IDLE;
            else                  byte_cnt <= byte_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign tx_start = tx_ready &&
                    (((state == ST_SEND) && (byte_cnt != 8'(DATA_BYTES))) ||
                     ((state == ST_ACK) && (byte_cnt == 8'd0)));
  assign tx_data  = (state == ST_ACK) ? ACK_BYTE : rd_shift[7:0];

  assign busy             = (state != ST_IDLE);
  assign bus.bus_addr     = addr_q;
  assign bus.bus_write_en = (state == ST_BUS_WR);
  assign bus.bus_data_out = data_q;

endmodule

// File: tb/tb_reflet_uart_bridge.sv
// Bench for reflet_uart_bridge: a host driver, a serial decoder on tx, a
// bus slave with fixed read data, and a transaction-level model holding
// the expected bus writes and expected reply bytes.
module tb_reflet_uart_bridge;

  localparam int WS       = 16;
  localparam int AS       = 16;
  localparam int CLK_FREQ = 96000;
  localparam int BAUD     = 9600;
  localparam int DIV      = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rx    = 1'b1;
  logic tx;
  logic busy;

  reflet_uart_bridge_if #(.wordsize(WS), .addr_size(AS)) bus ();

  reflet_uart_bridge #(
    .wordsize (WS),
    .addr_size(AS),
    .clk_freq (CLK_FREQ),
    .baud     (BAUD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rx   (rx),
    .tx   (tx),
    .busy (busy),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [WS-1:0] mem_read(input logic [AS-1:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  assign bus.bus_data_in = mem_read(bus.bus_addr);

  int n_checks = 0;
  int n_pass   = 0;
  int wr_count = 0;
  logic [7:0]       exp_tx[$];
  logic [7:0]       tx_log[$];
  logic [AS+WS-1:0] exp_wr[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic expect_write(input logic [AS-1:0] a, input logic [WS-1:0] d);
    exp_wr.push_back({a, d});
    exp_tx.push_back(8'h4B);
  endtask

  task automatic expect_read(input logic [AS-1:0] a);
    logic [WS-1:0] v;
    v = mem_read(a);
    for (int i = 0; i < WS / 8; i++) exp_tx.push_back(v[8*i +: 8]);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop = 1'b1);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = good_stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_read(input logic [7:0] lo, input logic [7:0] hi);
    send_byte(8'h52);
    send_byte(lo);
    send_byte(hi);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((busy || exp_tx.size() != 0 || exp_wr.size() != 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, 32'(n < 4000), 32'd1);
    repeat (5) @(negedge clk);
  endtask

  // Bus write monitor: every strobe must be expected and last one cycle.
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    if (bus.bus_write_en === 1'b1) begin
      wr_count++;
      check("we_one_cycle", 32'(prev_we), 32'd0);
      check("write_pending", 32'(exp_wr.size() > 0), 32'd1);
      if (exp_wr.size() > 0) begin
        logic [AS+WS-1:0] e;
        e = exp_wr.pop_front();
        check("write_addr", 32'(bus.bus_addr), 32'(e[AS+WS-1:WS]));
        check("write_data", 32'(bus.bus_data_out), 32'(e[WS-1:0]));
      end
    end
    prev_we = (bus.bus_write_en === 1'b1);
  end

  // Serial decoder on tx, sampling each bit at its centre.
  initial begin
    forever begin
      logic [7:0] b;
      logic st, sp;
      @(negedge tx);
      repeat (DIV / 2) @(negedge clk);
      st = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        b[i] = tx;
      end
      repeat (DIV) @(negedge clk);
      sp = tx;
      check("tx_start_bit", 32'(st), 32'd0);
      check("tx_stop_bit", 32'(sp), 32'd1);
      tx_log.push_back(b);
      check("tx_byte_pending", 32'(exp_tx.size() > 0), 32'd1);
      if (exp_tx.size() > 0) check("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we", 32'(bus.bus_write_en), 32'd0);
    check("rst_addr", 32'(bus.bus_addr), 32'd0);
    check("rst_data", 32'(bus.bus_data_out), 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Write 0xABCD to 0x1234
    expect_write(16'h1234, 16'hABCD);
    send_byte(8'h57);
    check("busy_after_cmd", 32'(busy), 32'd1);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'hCD);
    send_byte(8'hAB);
    wait_done("write");
    check("wr_addr", 32'(bus.bus_addr), 32'h1234);
    check("wr_data", 32'(bus.bus_data_out), 32'hABCD);
    check("wr_count", 32'(wr_count), 32'd1);
    check("ack_byte", 32'(tx_log[$]), 32'h4B);

    // Read 0x0010 -> BEEF
    expect_read(16'h0010);
    send_read(8'h10, 8'h00);
    wait_done("read");
    check("rd_lsb", 32'(tx_log[tx_log.size()-2]), 32'hEF);
    check("rd_msb", 32'(tx_log[$]), 32'hBE);
    check("rd_addr", 32'(bus.bus_addr), 32'h0010);
    check("rd_data_out_held", 32'(bus.bus_data_out), 32'hABCD);
    check("rd_no_write", 32'(wr_count), 32'd1);

    // Junk bytes in IDLE, then a read
    send_byte(8'h00);
    send_byte(8'hFF);
    repeat (DIV) @(negedge clk);
    check("junk_idle", 32'(busy), 32'd0);
    expect_read(16'h0010);
    send_read(8'h10, 8'h00);
    wait_done("junk_read");

    // Framing error on the command byte
    send_byte(8'h57, 1'b0);
    repeat (2 * DIV) @(negedge clk);
    check("ferr_idle", 32'(busy), 32'd0);
    expect_read(16'h0010);
    send_read(8'h10, 8'h00);
    wait_done("ferr_read");
    check("ferr_no_write", 32'(wr_count), 32'd1);

    // Framing error in the middle of the address returns to IDLE
    send_byte(8'h57);
    send_byte(8'h34);
    send_byte(8'h12, 1'b0);
    repeat (2 * DIV) @(negedge clk);
    check("ferr_addr_idle", 32'(busy), 32'd0);
    expect_read(16'h0010);
    send_read(8'h10, 8'h00);
    wait_done("ferr_addr_read");
    check("ferr_addr_no_write", 32'(wr_count), 32'd1);

    // Reset in the middle of DATA
    send_byte(8'h57);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'hCD);
    check("mid_data_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_tx", 32'(tx), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_we", 32'(bus.bus_write_en), 32'd0);
    check("rst_mid_addr", 32'(bus.bus_addr), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    expect_write(16'h5678, 16'h1357);
    send_byte(8'h57);
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h57);
    send_byte(8'h13);
    wait_done("post_rst_write");
    check("post_rst_addr", 32'(bus.bus_addr), 32'h5678);
    check("post_rst_data", 32'(bus.bus_data_out), 32'h1357);
    check("post_rst_count", 32'(wr_count), 32'd2);

    // Short low glitch on rx
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    check("glitch_idle", 32'(busy), 32'd0);
    check("glitch_no_write", 32'(wr_count), 32'd2);
    expect_read(16'h0020);
    send_read(8'h20, 8'h00);
    wait_done("glitch_read");
    check("rd2_lsb", 32'(tx_log[tx_log.size()-2]), 32'h7A);
    check("rd2_msb", 32'(tx_log[$]), 32'h5A);
    check("final_tx_idle", 32'(tx), 32'd1);
    check("final_tx_queue", 32'(exp_tx.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
